// File: rtl/wb_sram_ctrl.sv
// Wishbone B4 pipelined slave in front of a single-port word RAM.
// Adds address-window decode with error response, byte lanes, wait states and stall handshake.
module wb_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        stall_o,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_ERR} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [AW-1:0]   idx_q, idx_d;

  logic [31:0]     offset;
  logic            hit;
  logic            accept;

  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [3:0]      mem_sel;
  logic [31:0]     mem_wdat;
  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     rdata_q;

  // Window is aligned to its own size, so an address below BASE_ADDR wraps the
  // offset past WIN_BYTES and a single unsigned compare covers both bounds.
  assign offset = adr_i - BASE_ADDR;
  assign hit    = (offset[1:0] == 2'b00) && (offset < WIN_BYTES);
  assign accept = cyc_i && stb_i && (state_q == ST_IDLE);

  // NOTE: every signal written below gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdat_d   = wdat_q;
    idx_d    = idx_q;
    mem_en   = 1'b0;
    mem_we   = we_q;
    mem_idx  = idx_q;
    mem_sel  = sel_q;
    mem_wdat = wdat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d   = we_i;
          sel_d  = sel_i;
          wdat_d = dat_i;
          idx_d  = offset[AW+1:2];
          if (!hit) begin
            state_d = ST_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d  = ST_ACK;
            mem_en   = 1'b1;
            mem_we   = we_i;
            mem_idx  = offset[AW+1:2];
            mem_sel  = sel_i;
            mem_wdat = dat_i;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          mem_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the array and its read register have no reset so the RAM maps onto
  // block/SPRAM; dat_o is gated by state, so stale read data never escapes.
  always_ff @(posedge clk_i) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_sel[b]) mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[mem_idx];
      end
    end
  end

  assign stall_o = (state_q != ST_IDLE);
  assign ack_o   = (state_q == ST_ACK);
  assign err_o   = (state_q == ST_ERR);
  assign dat_o   = (state_q == ST_ACK && !we_q) ? rdata_q : 32'd0;
  assign rty_o   = 1'b0;

endmodule
